add_acc: RTL and testbench
==========================

ADD_ACC -- requirements
Module: add_acc

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand and result width in bits (legal range 2..32).
REQ-002 Parameter PIPE, default 2, sets the pipeline depth in register stages (legal range 1..4).
REQ-003 Port clk  input  1  is the single rising-edge clock for all state.
REQ-004 Port rst_n  input  1  is the asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  indicates that the operand set is valid.
REQ-006 Port in_ready  output  1  indicates that the block accepts operands this cycle.
REQ-007 Port a  input  WIDTH  is operand A.
REQ-008 Port b  input  WIDTH  is operand B, used in add mode only.
REQ-009 Port mode  input  1  selects the operation: 0 = add (a+b), 1 = accumulate (acc+a); it is sampled on accept.
REQ-010 Port clr  input  1  is a synchronous accumulator clear, sampled every cycle regardless of handshake.
REQ-011 Port out_valid  output  1  indicates that the result is valid.
REQ-012 Port out_ready  input  1  indicates that the downstream accepts the result.
REQ-013 Port c  output  WIDTH  is the result sum.
REQ-014 Port carry  output  1  is the carry-out, or the saturation flag when saturation is compiled in.

Function
REQ-015 An accept occurs on a rising edge where in_valid=1 and in_ready=1; a result delivery occurs on a rising edge where out_valid=1 and out_ready=1.
REQ-016 The internal sum SHALL be WIDTH+1 bits; c SHALL be sum[WIDTH-1:0] and carry SHALL be sum[WIDTH].
REQ-017 In mode 0 the result SHALL be a+b, and the accumulator SHALL remain unchanged.
REQ-018 In mode 1 the result SHALL be acc+a, and on the same edge acc SHALL be updated to that sum truncated to WIDTH bits; back-to-back mode-1 accepts chain without bubbles.
REQ-019 When clr=1 the accumulator SHALL be set to 0.
REQ-020 When clr=1 coincides with a mode-1 accept, the clear SHALL apply first, so the result equals a and acc becomes a.
REQ-021 The result of an accept at edge k SHALL present with out_valid=1 after edge k+PIPE-1, giving a latency of PIPE cycles, provided no stall occurs.
REQ-022 The pipeline SHALL use a global stall: every stage holds while out_valid=1 and out_ready=0.
REQ-023 in_ready SHALL equal out_ready OR NOT out_valid.
REQ-024 c, carry and out_valid SHALL remain stable while stalled.
REQ-025 Empty stages (bubbles) SHALL advance normally; out_valid SHALL be the valid bit of the last stage.
REQ-026 With continuous in_valid=1 and out_ready=1, throughput SHALL be one result per cycle.
REQ-027 Result order SHALL equal accept order; no result SHALL be dropped or duplicated.
REQ-028 The in_ready path SHALL be purely combinational from out_ready and state, with no combinational path from in_valid to in_ready.

Reset
REQ-029 On rst_n=0, all stage valid bits, acc, c and carry SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-030 After reset, out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-031 A reset asserted mid-operation SHALL discard all in-flight results, and none SHALL appear after release.
REQ-032 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-033 The macro ADD_ACC_SATURATE_EN SHALL control saturation as follows.
  - Defined: on overflow, c clamps to all ones, carry=1 flags saturation, and acc saturates to all ones (no wrap).
  - Undefined: arithmetic wraps modulo 2^WIDTH, and carry is the true carry-out.

Verification (WIDTH=8, PIPE=2)
REQ-034 Bench SHALL cover reset then add: a=0x01, b=0x01, mode=0 accepted at edge k, out_ready=1 -> c=0x02, carry=0, out_valid=1 after edge k+1, one cycle only.
REQ-035 Bench SHALL cover overflow: a=0xFF, b=0x02, mode=0.
  - Without the macro -> c=0x01, carry=1.
  - With ADD_ACC_SATURATE_EN -> c=0xFF, carry=1.
REQ-036 Bench SHALL cover accumulate: clr pulse, then a=0x10, 0x20, 0x30 in mode 1 on consecutive edges -> results 0x10, 0x30, 0x60 on consecutive cycles, and acc=0x60.
REQ-037 Bench SHALL cover backpressure: a stream of 4 adds with out_ready=0 for 3 cycles mid-stream.
  - Required: in_ready=0 and c held stable while stalled.
  - Required: all 4 results delivered in order, with none lost.
REQ-038 Bench SHALL cover clr with accept: acc=0x50, clr=1 with a mode-1 accept of a=0x07 -> result 0x07, acc=0x07.
REQ-039 Bench SHALL cover reset mid-flight: 2 results in the pipeline, rst_n pulsed low between edges -> out_valid=0 immediately, and no stale result after release.

Source files
------------

// File: rtl/add_acc.sv
// add_acc: pipelined adder / accumulator with a valid-ready handshake and a global stall.
// Define ADD_ACC_SATURATE_EN to clamp overflowing results (and the accumulator) to all ones.
module add_acc #(
  parameter int WIDTH = 8,
  parameter int PIPE  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             carry
);

  logic             stall;
  logic             accept;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   raw_sum;
  logic [WIDTH:0]   res_d;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [PIPE-1:0]  valid_q;
  logic [WIDTH:0]   data_q [PIPE];

  assign out_valid = valid_q[PIPE-1];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign accept    = in_valid & in_ready;
  assign c         = data_q[PIPE-1][WIDTH-1:0];
  assign carry     = data_q[PIPE-1][WIDTH];

  // A clear coinciding with an accumulate takes effect first, so the accumulator reads as zero.
  always_comb begin
    addend = b;
    if (mode) begin
      addend = clr ? '0 : acc_q;
    end
    raw_sum = {1'b0, a} + {1'b0, addend};
  end

  always_comb begin
`ifdef ADD_ACC_SATURATE_EN
    res_d = raw_sum[WIDTH] ? {1'b1, {WIDTH{1'b1}}} : raw_sum;
`else
    res_d = raw_sum;
`endif
  end

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end
    if (accept && mode) begin
      acc_d = res_d[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Every stage, bubbles included, holds while the last stage is valid but not taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < PIPE; i++) begin
        data_q[i] <= '0;
      end
    end else if (!stall) begin
      valid_q[0] <= accept;
      if (accept) begin
        data_q[0] <= res_d;
      end
      for (int i = 1; i < PIPE; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_add_acc.sv
// tb_add_acc: directed-vector bench for add_acc at WIDTH=8, PIPE=2.
module tb_add_acc;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       mode;
  logic       clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] c;
  logic       carry;

  int total = 0;
  int bad   = 0;

`ifdef ADD_ACC_SATURATE_EN
  localparam logic [8:0] OVF_EXP  = 9'h1FF;
  localparam logic [8:0] LAST_EXP = 9'h1FF;
`else
  localparam logic [8:0] OVF_EXP  = 9'h101;
  localparam logic [8:0] LAST_EXP = 9'h100;
`endif

  add_acc #(.WIDTH(8), .PIPE(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .carry     (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #23;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    total++;
    if ({carry, c} !== 9'h000) begin bad++; $display("[TB] FAIL reset_result: got %h want 000", {carry, c}); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    in_valid = 1'b1; a = 8'h01; b = 8'h01; mode = 1'b0;
    cycle();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL add_early_valid: got %b want 0", out_valid); end
    cycle();
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL add_valid: got %b want 1", out_valid); end
    total++;
    if ({carry, c} !== 9'h002) begin bad++; $display("[TB] FAIL add_result: got %h want 002", {carry, c}); end
    cycle();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL add_one_cycle: got %b want 0", out_valid); end
  endtask

  task automatic test_overflow();
    in_valid = 1'b1; a = 8'hFF; b = 8'h02; mode = 1'b0;
    cycle();
    in_valid = 1'b0;
    cycle();
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL ovf_valid: got %b want 1", out_valid); end
    total++;
    if ({carry, c} !== OVF_EXP) begin bad++; $display("[TB] FAIL ovf_result: got %h want %h", {carry, c}, OVF_EXP); end
    cycle();
  endtask

  task automatic test_accumulate();
    logic [7:0] expC [3];
    expC[0] = 8'h10; expC[1] = 8'h30; expC[2] = 8'h60;
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    in_valid = 1'b1; mode = 1'b1; b = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) a = 8'h10 * (i + 1);
      else in_valid = 1'b0;
      cycle();
      if (i > 0) begin
        total++;
        if (out_valid !== 1'b1 || {carry, c} !== {1'b0, expC[i-1]})
          begin bad++; $display("[TB] FAIL acc_step%0d: got v=%b %h want v=1 %h", i, out_valid, {carry, c}, {1'b0, expC[i-1]}); end
      end
    end
    in_valid = 1'b1; a = 8'h00;
    cycle();
    in_valid = 1'b0;
    cycle();
    total++;
    if (out_valid !== 1'b1 || {carry, c} !== 9'h060)
      begin bad++; $display("[TB] FAIL acc_value: got v=%b %h want v=1 060", out_valid, {carry, c}); end
    mode = 1'b0;
    cycle();
  endtask

  task automatic test_backpressure();
    logic [7:0] opA [4];
    logic [7:0] opB [4];
    logic [8:0] expR [4];
    int inIdx = 0;
    int outIdx = 0;
    logic stalled;
    logic accepted;
    logic [8:0] held;
    opA[0] = 8'h01; opB[0] = 8'h02; expR[0] = 9'h003;
    opA[1] = 8'h03; opB[1] = 8'h04; expR[1] = 9'h007;
    opA[2] = 8'h10; opB[2] = 8'h20; expR[2] = 9'h030;
    opA[3] = 8'h80; opB[3] = 8'h80; expR[3] = LAST_EXP;
    mode = 1'b0;
    for (int t = 0; t < 20; t++) begin
      out_ready = !(t >= 2 && t <= 4);
      in_valid = (inIdx < 4);
      if (inIdx < 4) begin a = opA[inIdx]; b = opB[inIdx]; end
      #1;
      if (t >= 2 && t <= 4) begin
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_ready_t%0d: got %b want 0", t, in_ready); end
      end
      stalled = out_valid && !out_ready;
      held = {carry, c};
      if (out_valid && out_ready) begin
        total++;
        if (outIdx >= 4) begin bad++; $display("[TB] FAIL bp_extra: got %h want none", {carry, c}); end
        else if ({carry, c} !== expR[outIdx])
          begin bad++; $display("[TB] FAIL bp_result%0d: got %h want %h", outIdx, {carry, c}, expR[outIdx]); end
        outIdx++;
      end
      accepted = in_valid && in_ready;
      cycle();
      if (accepted) inIdx++;
      if (stalled) begin
        total++;
        if (out_valid !== 1'b1 || {carry, c} !== held)
          begin bad++; $display("[TB] FAIL bp_hold_t%0d: got v=%b %h want v=1 %h", t, out_valid, {carry, c}, held); end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    total++;
    if (outIdx !== 4) begin bad++; $display("[TB] FAIL bp_count: got %0d want 4", outIdx); end
  endtask

  task automatic test_clr_accept();
    clr = 1'b1;
    cycle();
    clr = 1'b0; in_valid = 1'b1; mode = 1'b1; a = 8'h50;
    cycle();
    clr = 1'b1; a = 8'h07;
    cycle();
    total++;
    if (out_valid !== 1'b1 || {carry, c} !== 9'h050)
      begin bad++; $display("[TB] FAIL clr_pre: got v=%b %h want v=1 050", out_valid, {carry, c}); end
    clr = 1'b0; a = 8'h00;
    cycle();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || {carry, c} !== 9'h007)
      begin bad++; $display("[TB] FAIL clr_result: got v=%b %h want v=1 007", out_valid, {carry, c}); end
    cycle();
    total++;
    if (out_valid !== 1'b1 || {carry, c} !== 9'h007)
      begin bad++; $display("[TB] FAIL clr_acc: got v=%b %h want v=1 007", out_valid, {carry, c}); end
    mode = 1'b0;
    cycle();
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1; in_valid = 1'b1; mode = 1'b0;
    a = 8'h05; b = 8'h05;
    cycle();
    a = 8'h06; b = 8'h06;
    cycle();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || {carry, c} !== 9'h00A)
      begin bad++; $display("[TB] FAIL mid_pre: got v=%b %h want v=1 00a", out_valid, {carry, c}); end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || {carry, c} !== 9'h000)
      begin bad++; $display("[TB] FAIL mid_reset: got v=%b r=%b %h want v=0 r=1 000", out_valid, in_ready, {carry, c}); end
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_stale%0d: got %b want 0", i, out_valid); end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0; clr = 1'b0; out_ready = 1'b1;
    test_reset();
    test_add();
    test_overflow();
    test_accumulate();
    test_backpressure();
    test_clr_accept();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
